// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//
// Sequential 8x8 unsigned multiplier. One operand pair is accepted in IDLE,
// then sixteen 2x2 partial products are formed through a single shared
// 2x2 multiplier cell and shifted into a 16-bit accumulator, one per cycle.
// The product is presented in DONE until the consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   operand pair on A/B is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   A          8-bit unsigned multiplicand
//   B          8-bit unsigned multiplier
//   out_valid  product on P is valid (DONE only)
//   out_ready  consumer accepts P
//   P          16-bit unsigned product A*B
//   busy       high while in RUN or DONE
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mul
//
// 2x2 unsigned multiplier cell.
//
// Ports
//   a  2-bit operand
//   b  2-bit operand
//   p  4-bit product a*b
// -----------------------------------------------------------------------------
module mul (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   always_comb begin
      p = {2'b00, a} * {2'b00, b};
   end

endmodule

module mul_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] P,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [3:0]  k;
   logic [15:0] acc;
   logic [7:0]  a_reg;
   logic [7:0]  b_reg;

   logic [1:0]  i_idx;
   logic [1:0]  j_idx;
   logic [1:0]  mul_a;
   logic [1:0]  mul_b;
   logic [3:0]  pp;
   logic [3:0]  shamt;
   logic [15:0] pp_shifted;

   // -------------------------------------------------------------------------
   // Partial-product datapath. Step k selects digit i of A and digit j of B
   // (base 4); the product of those digits carries weight 4^(i+j).
   // -------------------------------------------------------------------------
   always_comb begin
      i_idx      = k[1:0];
      j_idx      = k[3:2];
      mul_a      = a_reg[{i_idx, 1'b0} +: 2];
      mul_b      = b_reg[{j_idx, 1'b0} +: 2];
      shamt      = {({1'b0, i_idx} + {1'b0, j_idx}), 1'b0};
      pp_shifted = {12'd0, pp} << shamt;
   end

   mul u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (pp)
   );

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end

         RUN: begin
            busy = 1'b1;
            // RUN always takes the full 16 steps, even for zero operands
            if (k == 4'd15) begin
               state_nxt = DONE;
            end
         end

         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // in_valid is ignored here: a new pair is only taken in IDLE
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Operand capture, step counter and accumulator
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         k     <= '0;
         acc   <= '0;
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= A;
                  b_reg <= B;
                  acc   <= '0;
                  k     <= '0;
               end
            end

            RUN: begin
               // Sum never exceeds 0xFE01, so the 16-bit add cannot overflow
               acc <= acc + pp_shifted;
               k   <= k + 4'd1;
            end

            default: begin
            end
         endcase
      end
   end

   // Accumulator holds its value outside RUN, so P is stable throughout DONE
   assign P = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] P;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   mul_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .P         (P),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      int          hold;
      logic        pulse;
      logic [15:0] exp_p;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   // advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " in_ready"},  {31'd0, in_ready},  32'd1);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " busy"},      {31'd0, busy},      32'd0);
      check({tag, " P"},         {16'd0, P},         32'h0000);
   endtask

   // One full transaction from IDLE: accept, 16 RUN cycles, DONE for
   // hold cycles with out_ready low, then handshake.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input logic pulse, input logic [15:0] exp_p);
      check("idle in_ready", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      A         = a;
      B         = b;
      out_ready = 1'b0;
      step();                           // accepting edge T
      in_valid = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
      check("run busy",     {31'd0, busy},      32'd1);
      check("run in_ready", {31'd0, in_ready},  32'd0);
      for (int c = 1; c <= 15; c++) begin
         if (pulse && c == 5) begin
            in_valid = 1'b1;
            A = 8'hAA;
            B = 8'h55;
         end else begin
            in_valid = 1'b0;
            A = 8'($urandom);
            B = 8'($urandom);
         end
         step();                        // after edge T+c
         check("run out_valid low", {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      step();                           // after edge T+16
      for (int h = 0; h < hold; h++) begin
         check("done out_valid", {31'd0, out_valid}, 32'd1);
         check("done P",         {16'd0, P},         {16'd0, exp_p});
         check("done in_ready",  {31'd0, in_ready},  32'd0);
         if (pulse) begin
            in_valid = 1'b1;
            A = 8'hAA;
            B = 8'h55;
         end
         step();
      end
      check("done out_valid", {31'd0, out_valid}, 32'd1);
      check("done P",         {16'd0, P},         {16'd0, exp_p});
      out_ready = 1'b1;
      if (pulse) begin
         in_valid = 1'b1;
         A = 8'hAA;
         B = 8'h55;
      end
      step();                           // handshake edge
      out_ready = 1'b0;
      check("post in_ready",  {31'd0, in_ready},  32'd1);
      check("post out_valid", {31'd0, out_valid}, 32'd0);
      check("post busy",      {31'd0, busy},      32'd0);
      if (pulse) begin
         // pair presented on the handshake cycle must not have been taken
         in_valid = 1'b0;
         step();
         check("no late accept busy", {31'd0, busy}, 32'd0);
      end
   endtask

   logic [15:0] sb_q[$];
   logic [15:0] exp_b2b;
   int          issued;
   int          received;

   initial begin
      vecs[0] = '{a: 8'h0D, b: 8'h0B, hold: 0, pulse: 1'b0, exp_p: 16'h008F};
      vecs[1] = '{a: 8'hFF, b: 8'hFF, hold: 0, pulse: 1'b0, exp_p: 16'hFE01};
      vecs[2] = '{a: 8'h00, b: 8'hFF, hold: 0, pulse: 1'b0, exp_p: 16'h0000};
      vecs[3] = '{a: 8'h12, b: 8'h34, hold: 5, pulse: 1'b0, exp_p: 16'h03A8};
      vecs[4] = '{a: 8'h03, b: 8'h07, hold: 1, pulse: 1'b1, exp_p: 16'h0015};
      vecs[5] = '{a: 8'h01, b: 8'h01, hold: 0, pulse: 1'b0, exp_p: 16'h0001};
      vecs[6] = '{a: 8'h80, b: 8'h02, hold: 2, pulse: 1'b0, exp_p: 16'h0100};
      vecs[7] = '{a: 8'hFF, b: 8'h01, hold: 0, pulse: 1'b0, exp_p: 16'h00FF};
      vecs[8] = '{a: 8'h5A, b: 8'hC3, hold: 0, pulse: 1'b0, exp_p: 16'h448E};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = 8'h00;
      B         = 8'h00;
      step();
      step();
      check_reset_state("reset");
      rst = 1'b0;

      foreach (vecs[n]) begin
         run_op(vecs[n].a, vecs[n].b, vecs[n].hold, vecs[n].pulse, vecs[n].exp_p);
      end

      // reset during RUN at step k=7 aborts the operation
      in_valid = 1'b1;
      A = 8'h77;
      B = 8'h99;
      step();                           // accept, k=0
      in_valid = 1'b0;
      for (int c = 1; c <= 7; c++) step();  // k=7
      rst = 1'b1;
      step();
      check_reset_state("mid-run reset");
      rst = 1'b0;
      run_op(8'h10, 8'h10, 0, 1'b0, 16'h0100);

      // reset held in DONE also aborts
      in_valid = 1'b1;
      A = 8'h21;
      B = 8'h03;
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= 16; c++) step();
      check("pre-reset done", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      rst = 1'b1;
      step();
      out_ready = 1'b0;
      check_reset_state("done reset");
      rst = 1'b0;

      // back-to-back: in_valid held high, random out_ready, scoreboard order
      issued   = 0;
      received = 0;
      for (int cyc = 0; cyc < 60000 && received < 1000; cyc++) begin
         A         = 8'($urandom);
         B         = 8'($urandom);
         in_valid  = (issued < 1000);
         out_ready = 1'($urandom_range(0, 1));
         if (in_valid && in_ready) begin
            sb_q.push_back(16'(A) * 16'(B));
            issued++;
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("b2b unexpected output", {31'd0, out_valid}, 32'd0);
            end else begin
               exp_b2b = sb_q.pop_front();
               check("b2b P", {16'd0, P}, {16'd0, exp_b2b});
            end
            received++;
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b received count", received, 32'd1000);
      check("b2b scoreboard empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair on A/B is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 A  input  8  multiplicand, unsigned.
REQ-007 B  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  product on P is valid.
REQ-009 out_ready  input  1  consumer accepts P.
REQ-010 P  output  16  unsigned product A*B.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The block SHALL compute all partial products through exactly one instance of the existing 2x2 multiplier cell (mul), time-shared across 16 cycles.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1. If in_valid=1, the block SHALL latch A and B into internal registers, clear the 16-bit accumulator, set the 4-bit step index k=0 and go to RUN.
REQ-015 RUN: at step k, with i=k[1:0] and j=k[3:2], the mul inputs SHALL be A_reg[2i+1:2i] and B_reg[2j+1:2j].
REQ-016 RUN: each cycle, acc <= acc + (pp << 2*(i+j)), where pp is the 4-bit mul output.
REQ-017 RUN: the addition SHALL be done at 16 bits; overflow beyond bit 15 cannot occur and no carry-out is kept.
REQ-018 RUN: k SHALL increment each cycle. After the k=15 accumulate, the FSM SHALL go to DONE.
REQ-019 RUN SHALL last exactly 16 cycles; it SHALL NOT be stalled or shortened, including for zero operands.
REQ-020 DONE: out_valid=1 and P=acc. P SHALL remain stable while out_ready=0.
REQ-021 DONE: if out_ready=1, the FSM SHALL go to IDLE on that edge.
REQ-022 Latency: for a pair accepted on edge T, out_valid SHALL first be high after edge T+16, provided RUN is not reset.
REQ-023 in_ready SHALL be 0 in RUN and DONE. in_valid in those states SHALL be ignored, with no latch and no queueing.
REQ-024 in_valid on the same cycle as the DONE handshake SHALL NOT be accepted; the earliest new acceptance is the following IDLE cycle.
REQ-025 Minimum issue interval SHALL be 18 cycles: 1 IDLE cycle, 16 RUN cycles and 1 DONE cycle.
REQ-026 A and B SHALL be sampled only on the accepting edge. Later changes on A/B SHALL NOT affect the result.
REQ-027 out_valid SHALL be 0 in IDLE and RUN. P SHALL hold its last value outside DONE (don't-care for checking).

Reset
REQ-028 While rst=1 at a rising edge, the next state SHALL be: FSM=IDLE, k=0, acc=0, A_reg=0, B_reg=0.
REQ-029 The resulting outputs SHALL be: in_ready=1, out_valid=0, busy=0, P=0x0000.
REQ-030 rst SHALL take priority over all handshakes. Reset in RUN or DONE SHALL abort the operation; no product is delivered and no partial result is retained.
REQ-031 The cycle after rst deasserts, the block SHALL accept a new pair if in_valid=1.

Verification
REQ-032 A=0x0D, B=0x0B accepted at edge T, out_ready=1 -> out_valid high after edge T+16, P=0x008F, back to IDLE after edge T+17.
REQ-033 A=0xFF, B=0xFF -> P=0xFE01. A=0x00, B=0xFF -> P=0x0000 with the same 16-cycle latency.
REQ-034 A=0x12, B=0x34 with out_ready held 0 for 5 cycles in DONE -> P=0x03A8 and out_valid=1 held for all 5 cycles; exit on the first out_ready=1.
REQ-035 in_valid pulsed with A=0xAA, B=0x55 during RUN of 0x03*0x07 -> result P=0x0015; the pulsed pair is never accepted.
REQ-036 rst asserted for 1 cycle at RUN step k=7 -> all reset values of REQ-028/REQ-029 next cycle, no out_valid. Next pair A=0x10, B=0x10 -> P=0x0100.
REQ-037 Back-to-back: 1000 random pairs, in_valid held high and random out_ready -> every P equals A*B, in issue order, and no accepted pair is lost.
